// File: rtl/apb_regbank_slave.sv
// ---------------------------------------------------------------------------
// apb_regbank_slave
//   APB completer that terminates setup/access transfers into a small
//   word-addressed register bank, with a fixed number of wait states per
//   transfer so the master's PREADY stall handling sees a real responder.
//
//   Build option:
//     APB_PSLVERR_EN  adds the PSLVERR port; an out-of-range or misaligned
//                     access then completes with PSLVERR=1 and read data
//                     32'hDEAD_BEEF. Without it, such writes are dropped and
//                     such reads return 0.
//
//   Parameters:
//     NUM_REGS     number of 32-bit registers (power of 2, 2..256)
//     BASE_ADDR    byte address of register 0 (aligned to 4*NUM_REGS)
//     WAIT_CYCLES  wait states per transfer (0..15)
//
//   Ports:
//     PCLK      in   bus clock, rising edge
//     PRESET    in   asynchronous reset, active low
//     PSEL      in   slave select
//     PENABLE   in   access phase indicator
//     PWRITE    in   1 = write, 0 = read
//     PRWADDR   in   byte address [31:0]
//     PRWDATA   in   write data [31:0]
//     PRWDATA1  out  read data [31:0], registered
//     PREADY    out  transfer completion, registered
//     PSLVERR   out  error response, registered (APB_PSLVERR_EN only)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// apb_regbank_slave_regs
//   Register storage plus address decode. Two decode ports: port a decodes
//   the live bus address (used for zero-wait reads at the setup edge), port b
//   decodes the address latched at setup and also selects the write target.
//
//   Ports:
//     clk_sys   in   clock
//     rst_b     in   asynchronous reset, active low
//     addr_a    in   byte address to decode on port a
//     ok_a      out  addr_a inside the bank and word aligned
//     rdata_a   out  register at addr_a, or BAD_RDATA when not ok_a
//     addr_b    in   byte address to decode on port b
//     ok_b      out  addr_b inside the bank and word aligned
//     rdata_b   out  register at addr_b, or BAD_RDATA when not ok_b
//     wr_en     in   write wr_data to addr_b (ignored when not ok_b)
//     wr_data   in   write data
// ---------------------------------------------------------------------------
module apb_regbank_slave_regs #(
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] BAD_RDATA = 32'h0000_0000
) (
   input  logic        clk_sys,
   input  logic        rst_b,
   input  logic [31:0] addr_a,
   output logic        ok_a,
   output logic [31:0] rdata_a,
   input  logic [31:0] addr_b,
   output logic        ok_b,
   output logic [31:0] rdata_b,
   input  logic        wr_en,
   input  logic [31:0] wr_data
);

   localparam int          IDX_W = $clog2(NUM_REGS);
   localparam logic [31:0] SPAN  = 32'(4 * NUM_REGS);

   logic [31:0]      regs [NUM_REGS];

   // 33-bit difference: bit 32 is the borrow, set when the address sits
   // below BASE_ADDR, so no separate lower-bound compare is needed.
   logic [32:0]      diff_a, diff_b;
   logic [IDX_W-1:0] idx_a, idx_b;

   always_comb begin
      diff_a  = {1'b0, addr_a} - {1'b0, BASE_ADDR};
      diff_b  = {1'b0, addr_b} - {1'b0, BASE_ADDR};
      ok_a    = !diff_a[32] && (diff_a[31:0] < SPAN) && (addr_a[1:0] == 2'b00);
      ok_b    = !diff_b[32] && (diff_b[31:0] < SPAN) && (addr_b[1:0] == 2'b00);
      idx_a   = diff_a[IDX_W+1:2];
      idx_b   = diff_b[IDX_W+1:2];
      rdata_a = ok_a ? regs[idx_a] : BAD_RDATA;
      rdata_b = ok_b ? regs[idx_b] : BAD_RDATA;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en && ok_b) begin
         regs[idx_b] <= wr_data;
      end
   end

endmodule

// ---------------------------------------------------------------------------
// Transfer FSM
//   state     | meaning
//   ST_IDLE   | waiting for a setup cycle (PSEL=1, PENABLE=0)
//   ST_ACCESS | setup seen; counting wait states, then completing
// ---------------------------------------------------------------------------
module apb_regbank_slave #(
   parameter int          NUM_REGS    = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PRWADDR,
   input  logic [31:0] PRWDATA,
   output logic [31:0] PRWDATA1,
   output logic        PREADY
`ifdef APB_PSLVERR_EN
   ,
   output logic        PSLVERR
`endif
);

`ifdef APB_PSLVERR_EN
   localparam logic [31:0] BAD_RDATA = 32'hDEAD_BEEF;
`else
   localparam logic [31:0] BAD_RDATA = 32'h0000_0000;
`endif
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
   localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] lat_addr;
   logic [31:0] lat_data;
   logic        lat_write;

   logic        setup_ok, acc_ok;
   logic [31:0] setup_rd, acc_rd;
   logic        commit;

   // A write lands on the completion edge, from the values latched at setup.
   assign commit = (state == ST_ACCESS) && PSEL && PENABLE && PREADY && lat_write;

   apb_regbank_slave_regs #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE_ADDR),
      .BAD_RDATA (BAD_RDATA)
   ) u_regs (
      .clk_sys (PCLK),
      .rst_b   (PRESET),
      .addr_a  (PRWADDR),
      .ok_a    (setup_ok),
      .rdata_a (setup_rd),
      .addr_b  (lat_addr),
      .ok_b    (acc_ok),
      .rdata_b (acc_rd),
      .wr_en   (commit),
      .wr_data (lat_data)
   );

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
         PREADY    <= 1'b0;
         PRWDATA1  <= '0;
`ifdef APB_PSLVERR_EN
         PSLVERR   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               // PENABLE without a preceding setup is not a transfer.
               if (PSEL && !PENABLE) begin
                  lat_addr  <= PRWADDR;
                  lat_data  <= PRWDATA;
                  lat_write <= PWRITE;
                  cnt       <= WAIT_LD;
                  PREADY    <= ZERO_WAIT;
                  state     <= ST_ACCESS;
`ifdef APB_PSLVERR_EN
                  PSLVERR   <= ZERO_WAIT && !setup_ok;
`endif
                  // Zero-wait reads must present data in the first access
                  // cycle, so decode the live address here.
                  if (ZERO_WAIT && !PWRITE) PRWDATA1 <= setup_rd;
               end
            end
            ST_ACCESS: begin
               if (!PSEL) begin
                  // Master abandoned the transfer.
                  PREADY <= 1'b0;
                  cnt    <= '0;
                  state  <= ST_IDLE;
`ifdef APB_PSLVERR_EN
                  PSLVERR <= 1'b0;
`endif
               end else if (PENABLE) begin
                  if (PREADY) begin
                     PREADY <= 1'b0;
                     state  <= ST_IDLE;
`ifdef APB_PSLVERR_EN
                     PSLVERR <= 1'b0;
`endif
                  end else begin
                     cnt <= cnt - 4'd1;
                     if (cnt == 4'd1) begin
                        PREADY <= 1'b1;
`ifdef APB_PSLVERR_EN
                        PSLVERR <= !acc_ok;
`endif
                        if (!lat_write) PRWDATA1 <= acc_rd;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
- APB completer (responder) for the codebase's APB master. It terminates setup/access transfers into a small word-addressed register bank.
- Wait-state insertion is programmable, so master PREADY stalling can be exercised against a real responder rather than a zero-wait stub.
- Sits on the shared PSEL/PENABLE/PWRITE/PRWADDR/PRWDATA bus and returns PRWDATA1/PREADY to the master.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of 2, 2..256.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to 4*NUM_REGS.
- WAIT_CYCLES, 0, wait states inserted per transfer; 0..15.

Ports:
- PCLK  in  1  bus clock; all state changes on rising edge.
- PRESET  in  1  asynchronous, active-low reset (0 = reset).
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PRWADDR  in  32  byte address from master.
- PRWDATA  in  32  write data from master.
- PRWDATA1  out  32  read data to master.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; present only with APB_PSLVERR_EN.

Behaviour:
- Reset (PRESET=0, async): state IDLE, PREADY=0, PRWDATA1=0, PSLVERR=0, all registers 0, wait counter 0, latched addr/data/dir 0.
- Internal state: IDLE, ACCESS. Outputs PREADY, PRWDATA1 and PSLVERR are registered.
- Setup:
  - Edge with PSEL=1, PENABLE=0 (from IDLE) latches PRWADDR, PRWDATA and PWRITE, then goes to ACCESS.
  - Same edge loads cnt<=WAIT_CYCLES and PREADY<=(WAIT_CYCLES==0).
  - For a read with WAIT_CYCLES==0, PRWDATA1 is also loaded on this edge.
- ACCESS, PREADY=0, PSEL=1, PENABLE=1:
  - cnt<=cnt-1.
  - When cnt==1, PREADY<=1; for a read, PRWDATA1 is loaded with the register value on the same edge.
- Timing result: PREADY is high in access cycle WAIT_CYCLES+1. A transfer spans 1 setup cycle plus WAIT_CYCLES+1 access cycles.
- Completion edge (ACCESS, PSEL=1, PENABLE=1, PREADY=1):
  - Write: commits latched data to reg[idx].
  - PREADY<=0, PSLVERR<=0, state goes to IDLE.
  - PRWDATA1 holds its last read value until the next read completes; it is never cleared by writes.
- Indexing:
  - idx = (latched_addr - BASE_ADDR) >> 2, truncated to log2(NUM_REGS) bits.
  - Address is valid iff BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS and addr[1:0]==0.
- Invalid address without the optional feature: write is dropped; read returns 0; PREADY timing is unchanged.
- Back-to-back: completion edge goes to IDLE. If the next cycle has PSEL=1, PENABLE=0, it is a new setup; no idle cycle is required.
- Abort: PSEL=0 while in ACCESS leads, on the next edge, to IDLE, PREADY<=0, cnt<=0, no register write, PRWDATA1 unchanged.
- Stray PENABLE=1 seen in IDLE (no prior setup): ignored, stays IDLE, PREADY stays 0.
- PRWADDR/PRWDATA/PWRITE changes during ACCESS: ignored; the values latched at setup are used.
- Reset mid-transfer: immediate return to reset values; a pending write is lost.

Optional Feature:
- Macro: APB_PSLVERR_EN.
- Defined:
  - PSLVERR port exists.
  - An invalid address drives PSLVERR=1 coincident with PREADY=1 on the completion cycle.
  - Write is suppressed; PRWDATA1 is loaded with 32'hDEAD_BEEF.
  - PSLVERR returns to 0 on the completion edge.
- Undefined: no PSLVERR port; invalid access behaves as in Behaviour (dropped write, read 0).

Test Plan:
- WAIT_CYCLES=0: write 15 to addr 4, then read addr 4 -> PREADY high in first access cycle of each; PRWDATA1=32'd15 at read completion.
- WAIT_CYCLES=2: read addr 4 after writing 32'hA5A5_0001 -> PREADY low for 2 access cycles, high on 3rd; PRWDATA1=32'hA5A5_0001.
- PSEL held high across 3 consecutive writes (addr 0, 4, 8 with data 1, 2, 3), no idle -> each completes; read-back returns 1, 2, 3.
- Abort: write 32'h55 to addr 8 with WAIT_CYCLES=3, drop PSEL after 1 access cycle -> PREADY never rises; read addr 8 returns prior value 0.
- Invalid address 32'h0000_0040 (NUM_REGS=16) read and write, and misaligned addr 6 -> with APB_PSLVERR_EN: PSLVERR=1 with PREADY, PRWDATA1=32'hDEAD_BEEF, no register changes; without it: read returns 0.
- Assert PRESET=0 during ACCESS of a write to addr 12 -> PREADY=0 immediately; after release, reading addr 12 returns 0.
